// File: rtl/camera_fifo_ctrl_pkg.sv
// Shared types and width helpers for the camera prefetch FIFO read-side burst scheduler.
// State encodings are fixed so that debug probes decode the same values everywhere.
package camera_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input longint unsigned value);
    int w;
    longint unsigned v;
    w = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Width of the per-frame word counters (must hold 0..frame_words).
  function automatic int cnt_width(input int frame_words);
    return clog2(longint'(frame_words) + 1);
  endfunction

  // Width of a burst length field (must hold 1..burst_len).
  function automatic int len_width(input int burst_len);
    return clog2(longint'(burst_len) + 1);
  endfunction

endpackage

// File: rtl/camera_burst_addr_gen.sv
// Frame bookkeeping: words remaining, offset in the buffer, buffer ring index,
// and the next burst's length and start address.
module camera_burst_addr_gen
  import camera_fifo_ctrl_pkg::*;
#(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 1280 * 720,
  parameter int NUM_BUF     = 3,
  parameter int BUF_STRIDE  = 2 ** 20,
  parameter int ADDR_W      = 28,
  parameter int CNT_W       = cnt_width(FRAME_WORDS),
  parameter int LEN_W       = len_width(BURST_LEN)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              sof_take,
  input  logic              burst_done,
  input  logic [LEN_W-1:0]  done_len,
  output logic [CNT_W-1:0]  remain,
  output logic              remain_nz,
  output logic [LEN_W-1:0]  next_len,
  output logic [ADDR_W-1:0] next_addr,
  output logic [1:0]        buf_idx,
  output logic              drop
);

  logic [CNT_W-1:0] offset;
  logic             first_q;

  // NOTE: async-reset flops use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      remain  <= '0;
      offset  <= '0;
      buf_idx <= '0;
      first_q <= 1'b1;
    end else if (sof_take) begin
      // The very first frame after reset lands in buffer 0 without advancing.
      if (!first_q) begin
        buf_idx <= (buf_idx == 2'(NUM_BUF - 1)) ? 2'd0 : buf_idx + 2'd1;
      end
      remain  <= CNT_W'(FRAME_WORDS);
      offset  <= '0;
      first_q <= 1'b0;
    end else if (burst_done) begin
      remain <= remain - CNT_W'(done_len);
      offset <= offset + CNT_W'(done_len);
    end
  end

  assign remain_nz = |remain;
  assign drop      = sof_take & remain_nz & ~first_q;

  assign next_len  = (32'(remain) >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remain);
  // Arithmetic is done at ADDR_W bits, which wraps exactly like truncation.
  assign next_addr = ADDR_W'(buf_idx) * ADDR_W'(BUF_STRIDE) + ADDR_W'(offset);

endmodule

// File: rtl/camera_fifo_burst_ctrl.sv
// Read-side scheduler: drains the prefetch FIFO into length-tagged write bursts
// toward the frame-buffer port and walks the ring of frame buffers.
module camera_fifo_burst_ctrl
  import camera_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 1280 * 720,
  parameter int NUM_BUF     = 3,
  parameter int BUF_STRIDE  = 2 ** 20,
  parameter int ADDR_W      = 28,
  parameter int LEN_W       = len_width(BURST_LEN)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              en,
  input  logic              frame_start,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wlast,
  output logic [1:0]        buf_idx,
  output logic              frame_done,
  output logic              frame_drop,
  output logic              busy
);

  localparam int CNT_W = cnt_width(FRAME_WORDS);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] beat_cnt, len_q;
  logic             sof_pend;
  logic             sof_take, start, beat, last_beat;

  logic [CNT_W-1:0]  remain;
  logic              remain_nz, drop;
  logic [LEN_W-1:0]  next_len;
  logic [ADDR_W-1:0] next_addr;

  camera_burst_addr_gen #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .NUM_BUF    (NUM_BUF),
    .BUF_STRIDE (BUF_STRIDE),
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .LEN_W      (LEN_W)
  ) u_addr_gen (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .sof_take  (sof_take),
    .burst_done(last_beat),
    .done_len  (len_q),
    .remain    (remain),
    .remain_nz (remain_nz),
    .next_len  (next_len),
    .next_addr (next_addr),
    .buf_idx   (buf_idx),
    .drop      (drop)
  );

  // Write-side handshake is combinational so pops track mem_wready exactly.
  assign mem_req    = (state == REQ);
  assign mem_wvalid = (state == DATA) & fifo_rd_vld;
  assign fifo_rd_en = (state == DATA) & mem_wready;
  assign mem_wlast  = (state == DATA) & (beat_cnt == len_q - LEN_W'(1));
  assign mem_wdata  = fifo_rd_data;
  assign mem_len    = len_q;
  assign busy       = (state != IDLE);
  assign beat       = mem_wvalid & mem_wready;
  assign last_beat  = beat & mem_wlast;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    sof_take  = 1'b0;
    start     = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending start-of-frame wins over launching another burst.
        if (sof_pend) begin
          sof_take = 1'b1;
        end else if (en && fifo_rd_vld && remain_nz) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ:     if (mem_gnt)   state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      beat_cnt   <= '0;
      len_q      <= '0;
      mem_addr   <= '0;
      sof_pend   <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      // A new pulse in the consuming cycle keeps the flag set.
      sof_pend   <= frame_start | (sof_pend & ~sof_take);
      frame_drop <= drop;
      frame_done <= last_beat & (32'(remain) == 32'(len_q));
      if (start) begin
        len_q    <= next_len;
        mem_addr <= next_addr;
      end
      if (state == REQ) beat_cnt <= '0;
      else if (beat)    beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_camera_fifo_burst_ctrl.sv
// Self-checking bench for camera_fifo_burst_ctrl: FIFO model, burst/data scoreboard,
// handshake vector table and hand-written sequences for grant delay, drop and reset.
module tb_camera_fifo_burst_ctrl;

  localparam int DATA_W      = 16;
  localparam int BURST_LEN   = 64;
  localparam int FRAME_WORDS = 160;
  localparam int NUM_BUF     = 3;
  localparam int BUF_STRIDE  = 4096;
  localparam int ADDR_W      = 28;
  localparam int LEN_W       = $clog2(BURST_LEN + 1);

  logic              rd_clk = 1'b0;
  logic              rd_rst = 1'b1;
  logic              en = 1'b0;
  logic              frame_start = 1'b0;
  logic              fifo_rd_vld = 1'b0;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic              fifo_rd_en;
  logic              mem_req;
  logic              mem_gnt = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_len;
  logic              mem_wvalid;
  logic              mem_wready = 1'b0;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wlast;
  logic [1:0]        buf_idx;
  logic              frame_done, frame_drop, busy;

  camera_fifo_burst_ctrl #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS),
    .NUM_BUF(NUM_BUF), .BUF_STRIDE(BUF_STRIDE), .ADDR_W(ADDR_W)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .en(en), .frame_start(frame_start),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast), .buf_idx(buf_idx), .frame_done(frame_done),
    .frame_drop(frame_drop), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    int addr;
    int len;
    int bidx;
  } burst_t;

  typedef struct packed {
    bit vld;
    bit rdy;
    bit exp_wvalid;
    bit exp_rd_en;
  } hs_vec_t;

  burst_t            exp_bursts[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] next_word = 16'h1000;

  bit vld_gate = 1'b1;
  bit pop_pending = 1'b0;
  bit prev_last = 1'b0;
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int beat_total = 0;
  int cur_len = 0;
  int beat_i = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic update_fifo();
    fifo_rd_vld  = vld_gate && (fifo_q.size() != 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      exp_data.push_back(next_word);
      next_word = next_word + 16'd1;
    end
    update_fifo();
  endtask

  task automatic push_frame(input int base, input int bidx);
    burst_t b;
    for (int off = 0; off < FRAME_WORDS; off += BURST_LEN) begin
      b.addr = base + off;
      b.len  = (FRAME_WORDS - off < BURST_LEN) ? FRAME_WORDS - off : BURST_LEN;
      b.bidx = bidx;
      exp_bursts.push_back(b);
    end
  endtask

  // Observes the cycle just before the edge: grants, beats, pops and pulses.
  task automatic sample();
    burst_t b;
    bit beat, pop;
    beat = mem_wvalid && mem_wready;
    pop  = fifo_rd_en && fifo_rd_vld;
    if (mem_req && mem_gnt) begin
      if (exp_bursts.size() == 0) begin
        check("unexpected_burst", 64'd1, 64'd0);
      end else begin
        b = exp_bursts.pop_front();
        check("burst_addr", 64'(mem_addr), 64'(b.addr));
        check("burst_len", 64'(mem_len), 64'(b.len));
        check("burst_buf", 64'(buf_idx), 64'(b.bidx));
        cur_len = b.len;
        beat_i  = 0;
      end
    end
    if (fifo_rd_en) check("rd_en_needs_wready", 64'(mem_wready), 64'd1);
    if (beat || pop) check("pop_eq_beat", 64'(pop), 64'(beat));
    if (beat) begin
      if (exp_data.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
      else check("wdata", 64'(mem_wdata), 64'(exp_data.pop_front()));
      check("wlast", 64'(mem_wlast), 64'(beat_i == cur_len - 1));
      beat_i++;
      beat_total++;
    end
    if (frame_done) begin
      check("done_after_last_beat", 64'(prev_last), 64'd1);
      done_cnt++;
    end
    if (frame_drop) drop_cnt++;
    prev_last   = beat && mem_wlast;
    pop_pending = pop;
  endtask

  task automatic step();
    @(negedge rd_clk);
    if (!rd_rst) sample();
    @(posedge rd_clk);
    #1;
    if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
    frame_start = 1'b0;
    update_fifo();
  endtask

  task automatic run_until_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    check("frame_done_count", 64'(done_cnt), 64'(target));
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_wvalid"}, 64'(mem_wvalid), 64'd0);
    check({tag, "_mem_wlast"}, 64'(mem_wlast), 64'd0);
    check({tag, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_frame_drop"}, 64'(frame_drop), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_buf_idx"}, 64'(buf_idx), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    hs_vec_t hs_tab[8];
    logic [ADDR_W-1:0] hold_addr;
    logic [LEN_W-1:0]  hold_len;
    int base_beats;
    bit seen_busy;

    // {fifo valid, wready} -> {mem_wvalid, fifo_rd_en} while in DATA
    hs_tab = '{'{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b1},
               '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1, 1'b1},
               '{1'b1, 1'b0, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b1, 1'b1}};

    // Reset state
    repeat (3) @(posedge rd_clk);
    #1;
    check_all_low("reset");
    check("reset_mem_len", 64'(mem_len), 64'd0);
    rd_rst = 1'b0;
    en = 1'b1; mem_gnt = 1'b1; mem_wready = 1'b1; vld_gate = 1'b1;

    // No frame started yet: FIFO contents must stay in place
    push_words(FRAME_WORDS);
    seen_busy = 1'b0;
    repeat (5) begin step(); seen_busy |= busy; end
    check("idle_without_frame_busy", 64'(seen_busy), 64'd0);
    check("idle_without_frame_fifo", 64'(fifo_q.size()), 64'(FRAME_WORDS));

    // Frame 1: bursts (0,64) (64,64) (128,32) in buffer 0
    push_frame(0, 0);
    frame_start = 1'b1;
    run_until_done(1, 400);
    check("f1_bursts_left", 64'(exp_bursts.size()), 64'd0);
    check("f1_drop_cnt", 64'(drop_cnt), 64'd0);

    // Frame 2: handshake table then random gaps, buffer 1
    push_words(FRAME_WORDS);
    push_frame(BUF_STRIDE, 1);
    frame_start = 1'b1;
    step();
    for (int i = 0; i < 20 && !(busy && !mem_req); i++) step();
    check("f2_reach_data", 64'(busy && !mem_req), 64'd1);
    for (int i = 0; i < 8; i++) begin
      vld_gate   = hs_tab[i].vld;
      mem_wready = hs_tab[i].rdy;
      update_fifo();
      #1;
      check("hs_wvalid", 64'(mem_wvalid), 64'(hs_tab[i].exp_wvalid));
      check("hs_rd_en", 64'(fifo_rd_en), 64'(hs_tab[i].exp_rd_en));
      step();
    end
    for (int i = 0; i < 3000 && done_cnt < 2; i++) begin
      vld_gate   = ($urandom_range(0, 3) != 0);
      mem_wready = ($urandom_range(0, 2) != 0);
      update_fifo();
      step();
    end
    check("f2_done", 64'(done_cnt), 64'd2);
    vld_gate = 1'b1; mem_wready = 1'b1;
    update_fifo();

    // Frame 3: grant held off for 10 cycles, buffer 2
    mem_gnt = 1'b0;
    push_words(FRAME_WORDS);
    push_frame(2 * BUF_STRIDE, 2);
    frame_start = 1'b1;
    step();
    for (int i = 0; i < 10 && !mem_req; i++) step();
    check("f3_req_seen", 64'(mem_req), 64'd1);
    hold_addr = mem_addr;
    hold_len  = mem_len;
    check("f3_req_addr", 64'(hold_addr), 64'(2 * BUF_STRIDE));
    repeat (10) begin
      step();
      check("gnt_wait_req", 64'(mem_req), 64'd1);
      check("gnt_wait_addr", 64'(mem_addr), 64'(hold_addr));
      check("gnt_wait_len", 64'(mem_len), 64'(hold_len));
      check("gnt_wait_rd_en", 64'(fifo_rd_en), 64'd0);
    end
    mem_gnt = 1'b1;
    step();
    check("data_after_gnt_req", 64'(mem_req), 64'd0);
    check("data_after_gnt_rd_en", 64'(fifo_rd_en), 64'd1);
    run_until_done(3, 400);

    // Frame 4: ring wraps back to buffer 0
    push_words(FRAME_WORDS);
    push_frame(0, 0);
    frame_start = 1'b1;
    run_until_done(4, 400);
    check("f4_buf_idx", 64'(buf_idx), 64'd0);

    // Frame 5 abandoned after its first burst; frame 6 goes to buffer 2
    push_words(BURST_LEN + FRAME_WORDS);
    exp_bursts.push_back('{BUF_STRIDE, BURST_LEN, 1});
    push_frame(2 * BUF_STRIDE, 2);
    frame_start = 1'b1;
    step();
    base_beats = beat_total;
    for (int i = 0; i < 200 && beat_total < base_beats + 40; i++) step();
    check("f5_mid_burst", 64'(busy), 64'd1);
    frame_start = 1'b1;
    run_until_done(5, 600);
    check("f5_drop_cnt", 64'(drop_cnt), 64'd1);
    check("f6_buf_idx", 64'(buf_idx), 64'd2);

    // Reset at beat 20 of a burst into buffer 0
    push_words(BURST_LEN);
    exp_bursts.push_back('{0, BURST_LEN, 0});
    frame_start = 1'b1;
    step();
    base_beats = beat_total;
    for (int i = 0; i < 200 && beat_total < base_beats + 20; i++) step();
    check("rst_mid_data_busy", 64'(busy && !mem_req), 64'd1);
    rd_rst = 1'b1;
    #1;
    check_all_low("async_rst");
    fifo_q.delete();
    exp_data.delete();
    exp_bursts.delete();
    pop_pending = 1'b0;
    prev_last = 1'b0;
    update_fifo();
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    push_words(FRAME_WORDS);
    seen_busy = 1'b0;
    repeat (10) begin step(); seen_busy |= busy; end
    check("post_rst_no_burst", 64'(seen_busy), 64'd0);
    push_frame(0, 0);
    frame_start = 1'b1;
    run_until_done(6, 400);
    check("post_rst_drop_cnt", 64'(drop_cnt), 64'd1);
    check("end_bursts_left", 64'(exp_bursts.size()), 64'd0);
    check("end_data_left", 64'(exp_data.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
